// File: rtl/tb_vip_slave_lat.sv
// Crossbar VIP slave memory model: word-addressed memory answering req/ack with
// fixed or LFSR-randomised latency, saturating counters and a sticky protocol flag.
package cross_bar_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
endpackage

module tb_vip_slave_lat #(
  parameter int          ADDR_W    = cross_bar_pkg::ADDR_W,
  parameter int          DATA_W    = cross_bar_pkg::DATA_W,
  parameter int          MEM_AW    = 8,
  parameter int          LAT_MIN   = 0,
  parameter int          LAT_MAX   = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              protocol_err
);
  localparam bit FIXED = (LAT_MIN == LAT_MAX);
  localparam int RANGE = LAT_MAX - LAT_MIN + 1;

  if (LAT_MIN < 0 || LAT_MAX < LAT_MIN || LAT_MAX > 255) begin : g_bad_lat
    $fatal(1, "tb_vip_slave_lat: illegal LAT_MIN/LAT_MAX window");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $fatal(1, "tb_vip_slave_lat: LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d, lfsr_step;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cmd_q, cmd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                err_q, err_d;
  logic [7:0]          lat_n;
  logic                commit, c_cmd;
  logic [MEM_AW-1:0]   c_idx;
  logic [DATA_W-1:0]   c_wdata;
  logic [DATA_W-1:0]   mem_q [2**MEM_AW];

  // Galois step, taps x^16+x^14+x^13+x^11
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign lat_n     = FIXED ? 8'(LAT_MIN)
                           : 8'(LAT_MIN + int'(lfsr_step % 16'(RANGE)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    commit   = 1'b0;
    c_cmd    = cmd_q;
    c_idx    = addr_q[MEM_AW-1:0];
    c_wdata  = wdata_q;
    case (state_q)
      IDLE: if (slave_req) begin
        addr_d  = slave_addr;
        cmd_d   = slave_cmd;
        wdata_d = slave_wdata;
        if (!FIXED) lfsr_d = lfsr_step;
        if (lat_n == 8'd0) begin
          // zero latency: the accept edge is also the commit edge
          state_d = ACK;
          commit  = 1'b1;
          c_cmd   = slave_cmd;
          c_idx   = slave_addr[MEM_AW-1:0];
          c_wdata = slave_wdata;
        end else begin
          state_d = WAIT;
          cnt_d   = lat_n;
        end
      end
      WAIT: begin
        if (!slave_req || slave_addr != addr_q || slave_cmd != cmd_q ||
            slave_wdata != wdata_q)
          err_d = 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ACK;
          commit  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      if (c_cmd) begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
      end else begin
        rdata_d = mem_q[c_idx];
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      addr_q   <= '0;
      cmd_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately unreset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (commit && c_cmd && !areset) mem_q[c_idx] <= c_wdata;
  end

  assign slave_ack    = (state_q == ACK);
  assign slave_rdata  = rdata_q;
  assign wr_cnt       = wr_cnt_q;
  assign rd_cnt       = rd_cnt_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_tb_vip_slave_lat.sv
// Bench for tb_vip_slave_lat: five instances with different latency windows,
// driven by directed and random accesses against a scoreboard memory model.
module tb_tb_vip_slave_lat;
  localparam int ND = 5;
  localparam int LMIN [ND] = '{0, 3, 1, 2, 5};
  localparam int LMAX [ND] = '{0, 3, 4, 2, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [ND];
  logic        req   [ND];
  logic        cmd   [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic        ack   [ND];
  logic [31:0] rdata [ND];
  logic [15:0] wrc   [ND];
  logic [15:0] rdc   [ND];
  logic        perr  [ND];

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_mem [ND][256];
  bit          sb_vld [ND][256];
  int          sb_wr  [ND];
  int          sb_rd  [ND];

  for (genvar i = 0; i < ND; i++) begin : g_dut
    localparam int CW = (i == 0) ? 4 : 16;
    logic [CW-1:0] wc, rc;
    tb_vip_slave_lat #(
      .ADDR_W(32), .DATA_W(32), .MEM_AW(8),
      .LAT_MIN(LMIN[i]), .LAT_MAX(LMAX[i]),
      .LFSR_SEED(16'hACE1), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .areset(rst[i]),
      .slave_req(req[i]), .slave_addr(addr[i]), .slave_cmd(cmd[i]),
      .slave_wdata(wdata[i]), .slave_ack(ack[i]), .slave_rdata(rdata[i]),
      .wr_cnt(wc), .rd_cnt(rc), .protocol_err(perr[i])
    );
    assign wrc[i] = 16'(wc);
    assign rdc[i] = 16'(rc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cmax(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  task automatic sb_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    sb_mem[d][a[7:0]] = wd;
    sb_vld[d][a[7:0]] = 1'b1;
    if (sb_wr[d] < cmax(d)) sb_wr[d]++;
  endtask

  // Full handshake; returns cycles from req assertion to ack seen.
  task automatic xact(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, output int lat);
    req[d] = 1'b1; cmd[d] = wr; addr[d] = a; wdata[d] = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack[d] && lat < 400);
    req[d] = 1'b0;
    if (!ack[d]) chk("ack_timeout", 64'(ack[d]), 64'd1);
    if (wr) sb_write(d, a, wd);
    else begin
      if (sb_rd[d] < cmax(d)) sb_rd[d]++;
      if (sb_vld[d][a[7:0]]) chk("rd_data", rdata[d], sb_mem[d][a[7:0]]);
    end
    @(posedge clk); #1;
    chk("ack_width", 64'(ack[d]), 64'd0);
  endtask

  task automatic dut_reset(input int d);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    sb_wr[d] = 0;
    sb_rd[d] = 0;
  endtask

  task automatic wait_ack(input int d, output int n);
    n = 0;
    while (!ack[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, ndiff;
    int lat1 [200];
    int lat2 [200];
    bit seen [6];
    bit wr;
    logic [31:0] a, wd;

    for (int i = 0; i < ND; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; cmd[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      sb_wr[i] = 0; sb_rd[i] = 0;
    end
    for (int i = 0; i < 6; i++) seen[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) rst[i] = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < ND; i++) begin
      chk("rst_ack", 64'(ack[i]), 64'd0);
      chk("rst_rdata", rdata[i], 64'd0);
      chk("rst_wr_cnt", wrc[i], 64'd0);
      chk("rst_rd_cnt", rdc[i], 64'd0);
      chk("rst_perr", 64'(perr[i]), 64'd0);
    end

    // zero latency
    xact(0, 1'b1, 32'h05, 32'hDEADBEEF, lat);
    chk("l0_wr_lat", lat, 1);
    xact(0, 1'b0, 32'h05, 32'h0, lat);
    chk("l0_rd_lat", lat, 1);
    chk("l0_rd_val", rdata[0], 32'hDEADBEEF);
    chk("l0_wr_cnt", wrc[0], 1);
    chk("l0_rd_cnt", rdc[0], 1);
    chk("l0_perr", 64'(perr[0]), 0);

    // aliasing: bits above MEM_AW ignored
    xact(0, 1'b1, 32'h100, 32'h11, lat);
    xact(0, 1'b1, 32'h200, 32'h22, lat);
    xact(0, 1'b0, 32'h000, 32'h0, lat);
    chk("alias_val", rdata[0], 32'h22);

    // saturation on the 4-bit counter
    for (int k = 0; k < 20; k++) xact(0, 1'b1, 32'($urandom_range(0, 255)), $urandom, lat);
    chk("sat_wr_cnt", wrc[0], 15);
    chk("sat_wr_sb", wrc[0], sb_wr[0]);
    chk("sat_rd_cnt", rdc[0], 2);

    // fixed latency 3
    xact(1, 1'b1, 32'h33, 32'hCAFEF00D, lat);
    chk("l3_wr_lat", lat, 4);
    xact(1, 1'b0, 32'h33, 32'h0, lat);
    chk("l3_rd_lat", lat, 4);
    chk("l3_rd_val", rdata[1], 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #1;
    chk("l3_hold", rdata[1], 32'hCAFEF00D);
    xact(1, 1'b1, 32'h34, 32'h12345678, lat);
    chk("l3_hold_wr", rdata[1], 32'hCAFEF00D);

    // random latency window 1..4
    for (int k = 0; k < 200; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      wd = $urandom;
      xact(2, wr, a, wd, lat1[k]);
      chk("rnd_lat_range", 64'(lat1[k] >= 2 && lat1[k] <= 5), 1);
      if (lat1[k] >= 2 && lat1[k] <= 5) seen[lat1[k]] = 1'b1;
    end
    chk("rnd_all_lat", 64'(seen[2] && seen[3] && seen[4] && seen[5]), 1);
    chk("rnd_wr_cnt", wrc[2], sb_wr[2]);
    chk("rnd_rd_cnt", rdc[2], sb_rd[2]);
    dut_reset(2);
    for (int k = 0; k < 200; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15));
      wd = $urandom;
      xact(2, wr, a, wd, lat2[k]);
    end
    ndiff = 0;
    for (int k = 0; k < 200; k++) if (lat1[k] != lat2[k]) ndiff++;
    chk("rnd_repro", ndiff, 0);

    // protocol violation: wdata changes after accept
    req[3] = 1'b1; cmd[3] = 1'b1; addr[3] = 32'h10; wdata[3] = 32'hAAAA5555;
    @(posedge clk); #1;
    wdata[3] = 32'h12345678;
    wait_ack(3, n);
    chk("perr_ack", 64'(ack[3]), 1);
    chk("perr_lat", n, 2);
    chk("perr_set", 64'(perr[3]), 1);
    req[3] = 1'b0;
    @(posedge clk); #1;
    sb_write(3, 32'h10, 32'hAAAA5555);
    xact(3, 1'b0, 32'h10, 32'h0, lat);
    chk("perr_mem", rdata[3], 32'hAAAA5555);
    chk("perr_sticky", 64'(perr[3]), 1);
    chk("perr_wr_cnt", wrc[3], 1);

    // protocol violation: req dropped after accept
    dut_reset(3);
    chk("perr_clr", 64'(perr[3]), 0);
    req[3] = 1'b1; cmd[3] = 1'b1; addr[3] = 32'h11; wdata[3] = 32'h00005A5A;
    @(posedge clk); #1;
    req[3] = 1'b0;
    wait_ack(3, n);
    chk("drop_ack", 64'(ack[3]), 1);
    chk("drop_perr", 64'(perr[3]), 1);
    @(posedge clk); #1;
    sb_write(3, 32'h11, 32'h00005A5A);
    xact(3, 1'b0, 32'h11, 32'h0, lat);
    chk("drop_mem", rdata[3], 32'h00005A5A);

    // reset mid-write
    xact(4, 1'b1, 32'h20, 32'h0BADF00D, lat);
    chk("l5_wr_lat", lat, 6);
    req[4] = 1'b1; cmd[4] = 1'b1; addr[4] = 32'h20; wdata[4] = 32'hFFFF0000;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst[4] = 1'b1;
    #1;
    chk("mid_rst_ack", 64'(ack[4]), 0);
    chk("mid_rst_wr_cnt", wrc[4], 0);
    chk("mid_rst_rd_cnt", rdc[4], 0);
    chk("mid_rst_perr", 64'(perr[4]), 0);
    req[4] = 1'b0;
    @(posedge clk); #1;
    rst[4] = 1'b0;
    sb_wr[4] = 0; sb_rd[4] = 0;
    xact(4, 1'b0, 32'h20, 32'h0, lat);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_mem", rdata[4], 32'h0BADF00D);
    chk("post_rst_rd_cnt", rdc[4], 1);
    chk("post_rst_wr_cnt", wrc[4], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
